// File: rtl/random_word_arbiter_pkg.sv
// Shared definitions for the random word arbiter: FSM state encoding and word width.
package random_word_arbiter_pkg;

    localparam int RND_W = 16;

    typedef enum logic [2:0] {
        S_WARMUP = 3'd0,
        S_IDLE   = 3'd1,
        S_GRANT  = 3'd2,
        S_REFILL = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

endpackage

// File: rtl/random_word_arbiter_if.sv
// Bundle between the entropy source, the arbiter and its consumers.
interface random_word_arbiter_if #(
    parameter int NREQ = 4
);
    import random_word_arbiter_pkg::*;

    logic [RND_W-1:0] rnd_word;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [RND_W-1:0] data;
    logic             avail;
    logic             fault;

    modport master (
        output rnd_word, req,
        input  ack, data, avail, fault
    );

    modport slave (
        input  rnd_word, req,
        output ack, data, avail, fault
    );

endinterface

// File: rtl/random_word_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr wins.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_any
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;
    int               w_sum;

    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        w_sum    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_found && i_req[w_idx]) begin
                w_found         = 1'b1;
                o_grant[w_idx]  = 1'b1;
                o_winner        = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/random_word_arbiter.sv
// Shares one LFSR word source between NREQ requesters with warm-up, reseed gap
// and a sticky repetition health test.
module random_word_arbiter
    import random_word_arbiter_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int RESEED_CYCLES = 16,
    parameter int WARMUP_CYCLES = 256,
    parameter int STUCK_LIMIT   = 3
) (
    input  logic                 CLK,
    input  logic                 reset,
    random_word_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);
    localparam int REP_W = $clog2(STUCK_LIMIT + 1);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic [RND_W-1:0] r_lastWord;
    logic [REP_W-1:0] r_repCnt;
    logic [NREQ-1:0]  r_ack;
    logic [RND_W-1:0] r_data;

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [PTR_W-1:0] w_ptrNext;
    logic [RND_W-1:0] w_lastNext;
    logic [REP_W-1:0] w_repNext;
    logic [REP_W-1:0] w_repInc;
    logic [NREQ-1:0]  w_ackNext;
    logic [RND_W-1:0] w_dataNext;
    logic [NREQ-1:0]  w_grant;
    logic [PTR_W-1:0] w_winner;
    logic             w_any;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // One counter serves both warm-up and refill since the two never overlap.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_ptrNext   = r_ptr;
        w_lastNext  = r_lastWord;
        w_repNext   = r_repCnt;
        w_repInc    = r_repCnt;
        w_ackNext   = '0;
        w_dataNext  = '0;
        case (r_state)
            S_WARMUP: begin
                if (r_cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
                    w_stateNext = S_IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_any) begin
                    if (bus.rnd_word == r_lastWord) begin
                        w_repInc = (r_repCnt == REP_MAX) ? r_repCnt : r_repCnt + 1'b1;
                    end else begin
                        w_repInc = '0;
                    end
                    w_repNext  = w_repInc;
                    w_lastNext = bus.rnd_word;
                    // A stuck source is never delivered, not even the triggering word.
                    if (w_repInc >= REP_W'(STUCK_LIMIT)) begin
                        w_stateNext = S_FAULT;
                    end else begin
                        w_stateNext = S_GRANT;
                        w_ackNext   = w_grant;
                        w_dataNext  = bus.rnd_word;
                        w_ptrNext   = (w_winner == PTR_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                    end
                end
            end
            S_GRANT: begin
                w_stateNext = S_REFILL;
                w_cntNext   = '0;
            end
            S_REFILL: begin
                if (r_cnt == CNT_W'(RESEED_CYCLES - 1)) begin
                    w_stateNext = S_IDLE;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                w_stateNext = S_FAULT;
            end
            default: begin
                w_stateNext = S_WARMUP;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state    <= S_WARMUP;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_lastWord <= '0;
            r_repCnt   <= '0;
            r_ack      <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_ptr      <= w_ptrNext;
            r_lastWord <= w_lastNext;
            r_repCnt   <= w_repNext;
            r_ack      <= w_ackNext;
            r_data     <= w_dataNext;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.data  = r_data;
    assign bus.avail = (r_state == S_IDLE);
    assign bus.fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_random_word_arbiter.sv
// Directed bench for random_word_arbiter: warm-up, round-robin spacing, health test,
// reset during refill and after fault, dropped requests.
module tb_random_word_arbiter;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    int   nAsserts = 0;
    int   nFails   = 0;
    logic [15:0] w;
    logic [3:0]  expAck;
    logic [3:0]  reqv;

    random_word_arbiter_if #(.NREQ(4)) bus();

    random_word_arbiter #(
        .NREQ          (4),
        .RESEED_CYCLES (16),
        .WARMUP_CYCLES (256),
        .STUCK_LIMIT   (3)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic rstN, input logic [3:0] reqIn, input logic [15:0] rndIn);
        reset        = rstN;
        bus.req      = reqIn;
        bus.rnd_word = rndIn;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eAck, input logic [15:0] eData,
                               input logic eAvail, input logic eFault);
        nAsserts++;
        assert (bus.ack === eAck) else begin
            nFails++;
            $error("[TB] FAIL %s ack: observed %b expected %b", tag, bus.ack, eAck);
        end
        nAsserts++;
        assert (bus.data === eData) else begin
            nFails++;
            $error("[TB] FAIL %s data: observed %h expected %h", tag, bus.data, eData);
        end
        nAsserts++;
        assert (bus.avail === eAvail) else begin
            nFails++;
            $error("[TB] FAIL %s avail: observed %b expected %b", tag, bus.avail, eAvail);
        end
        nAsserts++;
        assert (bus.fault === eFault) else begin
            nFails++;
            $error("[TB] FAIL %s fault: observed %b expected %b", tag, bus.fault, eFault);
        end
    endtask

    // 256 silent warm-up clocks, then the held request is served on clock 257.
    task automatic runWarmup(input string tag, input logic [3:0] reqIn, input logic [15:0] word,
                             input logic [3:0] eAck);
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(1'b1, reqIn, word);
            checkOutput(tag, 4'b0000, 16'h0000, (k == 256), 1'b0);
        end
        applyStimulus(1'b1, reqIn, word);
        checkOutput(tag, eAck, word, 1'b0, 1'b0);
    endtask

    initial begin
        bus.req      = 4'b0000;
        bus.rnd_word = 16'h1234;

        applyStimulus(1'b0, 4'b0000, 16'h1234);
        applyStimulus(1'b0, 4'b0001, 16'h1234);
        checkOutput("reset", 4'b0000, 16'h0000, 1'b0, 1'b0);

        runWarmup("warmup", 4'b0001, 16'hC3C3, 4'b0001);

        for (int i = 1; i <= 72; i++) begin
            w = 16'h1000 + 16'(i);
            applyStimulus(1'b1, 4'b1111, w);
            if (i % 18 == 0) begin
                expAck = 4'(1 << ((i / 18) % 4));
                checkOutput("round_robin", expAck, w, 1'b0, 1'b0);
            end else begin
                checkOutput("round_robin", 4'b0000, 16'h0000, (i % 18 == 17), 1'b0);
            end
        end

        for (int i = 1; i <= 110; i++) begin
            applyStimulus(1'b1, 4'b0100, 16'hA5A5);
            expAck = (i == 18 || i == 36 || i == 54) ? 4'b0100 : 4'b0000;
            checkOutput("stuck", expAck, (expAck != 4'b0000) ? 16'hA5A5 : 16'h0000,
                        (i % 18 == 17) && (i < 72), (i >= 72));
        end

        applyStimulus(1'b0, 4'b0100, 16'h5A5A);
        checkOutput("reset_from_fault", 4'b0000, 16'h0000, 1'b0, 1'b0);
        runWarmup("rewarm_after_fault", 4'b0001, 16'h7E01, 4'b0001);

        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 4'b1000, 16'h2000 + 16'(i));
            checkOutput("refill", 4'b0000, 16'h0000, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'b1000, 16'h2222);
        checkOutput("reset_in_refill", 4'b0000, 16'h0000, 1'b0, 1'b0);
        runWarmup("rewarm_after_refill", 4'b1000, 16'h6C6C, 4'b1000);

        // req[1] only appears mid-refill and is gone before S_IDLE.
        for (int i = 1; i <= 18; i++) begin
            w    = 16'h3000 + 16'(i);
            reqv = (i >= 2 && i <= 10) ? 4'b1010 : 4'b1000;
            applyStimulus(1'b1, reqv, w);
            if (i == 18) checkOutput("dropped_req", 4'b1000, w, 1'b0, 1'b0);
            else         checkOutput("dropped_req", 4'b0000, 16'h0000, (i == 17), 1'b0);
        end

        for (int i = 1; i <= 18; i++) begin
            w = 16'h4000 + 16'(i);
            applyStimulus(1'b1, 4'b1010, w);
            if (i == 18) checkOutput("ptr_wrap", 4'b0010, w, 1'b0, 1'b0);
            else         checkOutput("ptr_wrap", 4'b0000, 16'h0000, (i == 17), 1'b0);
        end

        for (int i = 1; i <= 25; i++) begin
            applyStimulus(1'b1, 4'b0000, 16'h5000 + 16'(i));
            checkOutput("idle_no_req", 4'b0000, 16'h0000, (i >= 17), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
